// File: rtl/bottleneck_pkg.sv
// Shared Bottleneck_Layer constants, dilated-kernel geometry and feed FSM encoding.
// No logic and no latency; nothing here applies back-pressure.
package bottleneck_pkg;

  localparam int DATA_BITWIDTH  = 8;
  localparam int NUM_OF_CHANNEL = 32;
  localparam int NUM_OF_WEIGHT  = 32;

  localparam int KW       = 3;
  localparam int KH       = 3;
  localparam int DILATION = 3;

  // Inserting (DILATION-1) zeros between taps grows a K-wide kernel to this width.
  function automatic int dilated_k(input int k, input int d);
    return (k - 1) * (d - 1) + k;
  endfunction

  localparam int DKW      = dilated_k(KW, DILATION);
  localparam int DKH      = dilated_k(KH, DILATION);
  localparam int NUM_TAPS = DKW * DKH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_t;

endpackage

// File: rtl/bn_tap_counter.sv
// Loadable up-counter with clear (highest priority), load, enable and terminal flag.
// Count updates one cycle after en; term is combinational from the count; no back-pressure.
module bn_tap_counter #(
  parameter int W        = 4,
  parameter int TERMINAL = 1
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  localparam logic [W-1:0] TERM_V = W'(TERMINAL);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign term = (cnt == TERM_V);

endmodule

// File: rtl/bottleneck_feed_ctrl.sv
// Sequences one Bottleneck_Layer pass: buffer reads in tap order, layer strobes, drain, done.
// First beat 2 cycles after start; stalls on lyr_ready low, holding the tap and address.
module bottleneck_feed_ctrl #(
  parameter int  KW           = bottleneck_pkg::KW,
  parameter int  KH           = bottleneck_pkg::KH,
  parameter int  DILATION     = bottleneck_pkg::DILATION,
  parameter int  NUM_PIXELS   = 9,
  parameter int  DRAIN_CYCLES = 4,
  localparam int NUM_TAPS     = bottleneck_pkg::dilated_k(KW, DILATION) *
                                bottleneck_pkg::dilated_k(KH, DILATION),
  localparam int WADDR_W      = $clog2(NUM_TAPS),
  localparam int IADDR_W      = $clog2(NUM_PIXELS)
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               iact_rd_en,
  output logic [IADDR_W-1:0] iact_addr,
  output logic               wght_rd_en,
  output logic [WADDR_W-1:0] wght_addr,
  input  logic               lyr_ready,
  output logic               lyr_iact_vld,
  output logic               lyr_wght_vld,
  output logic               lyr_first,
  output logic               lyr_last,
  output logic               oact_vld
);

  import bottleneck_pkg::*;

  // One extra bit so the tap count can never alias back onto a valid address.
  localparam int TCNT_W = WADDR_W + 1;
  localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [TCNT_W-1:0]  PIX_END    = TCNT_W'(NUM_PIXELS);
  localparam logic [IADDR_W-1:0] PIX_LAST   = IADDR_W'(NUM_PIXELS - 1);
  localparam logic [DCNT_W-1:0]  DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

  feed_state_t       state;
  logic [TCNT_W-1:0] tap_cnt;
  logic              tap_term;
  logic              tap_clr;
  logic [DCNT_W-1:0] drain_cnt;
  logic              drain_term;
  logic              drain_clr;
  logic              drain_en;
  logic              in_feed;
  logic              issue;
  logic              pix_ok;

  assign in_feed = (state == ST_FEED);
  assign issue   = in_feed && lyr_ready;
  assign pix_ok  = (tap_cnt < PIX_END);

  // Cleared outside FEED and after the final tap so every pass starts from tap 0.
  assign tap_clr   = abort || !in_feed || (issue && tap_term);
  assign drain_clr = abort || (state != ST_DRAIN);
  assign drain_en  = (state == ST_DRAIN) && !drain_term;

  bn_tap_counter #(
    .W        (TCNT_W),
    .TERMINAL (NUM_TAPS - 1)
  ) u_tap_cnt (
    .clk      (clk),
    .rstN     (rstN),
    .clr      (tap_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (issue),
    .cnt      (tap_cnt),
    .term     (tap_term)
  );

  bn_tap_counter #(
    .W        (DCNT_W),
    .TERMINAL (DRAIN_CYCLES - 1)
  ) u_drain_cnt (
    .clk      (clk),
    .rstN     (rstN),
    .clr      (drain_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (drain_en),
    .cnt      (drain_cnt),
    .term     (drain_term)
  );

  // Buffer side: reads follow the tap counter; iact reads stop after the last pixel.
  always_comb begin
    wght_rd_en = 1'b0;
    iact_rd_en = 1'b0;
    wght_addr  = '0;
    iact_addr  = '0;
    if (in_feed) begin
      wght_rd_en = lyr_ready;
      iact_rd_en = lyr_ready && pix_ok;
      wght_addr  = tap_cnt[WADDR_W-1:0];
      iact_addr  = pix_ok ? tap_cnt[IADDR_W-1:0] : PIX_LAST;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      oact_vld     <= 1'b0;
      lyr_wght_vld <= 1'b0;
      lyr_iact_vld <= 1'b0;
      lyr_first    <= 1'b0;
      lyr_last     <= 1'b0;
    end else begin
      done     <= 1'b0;
      oact_vld <= 1'b0;
      // Strobes trail the reads by one cycle to line up with buffer dout.
      lyr_wght_vld <= wght_rd_en && !abort;
      lyr_iact_vld <= iact_rd_en && !abort;
      lyr_first    <= issue && (tap_cnt == '0) && !abort;
      lyr_last     <= issue && tap_term && !abort;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_FEED;
              busy  <= 1'b1;
            end
          end
          ST_FEED: begin
            if (issue && tap_term) begin
              state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              oact_vld <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bottleneck_feed_ctrl.sv
// Bench for bottleneck_feed_ctrl: directed passes with random and directed stalls, abort, reset.
// Expected behaviour comes from a pass-level model of taps issued, drain length and busy window.
module tb_bottleneck_feed_ctrl;

  localparam int NT = 49;
  localparam int NP = 9;
  localparam int DR = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic       abort;
  logic       lyr_ready;
  logic       busy;
  logic       done;
  logic       iact_rd_en;
  logic [3:0] iact_addr;
  logic       wght_rd_en;
  logic [5:0] wght_addr;
  logic       lyr_iact_vld;
  logic       lyr_wght_vld;
  logic       lyr_first;
  logic       lyr_last;
  logic       oact_vld;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bottleneck_feed_ctrl dut (
    .clk          (clk),
    .rstN         (rstN),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .iact_rd_en   (iact_rd_en),
    .iact_addr    (iact_addr),
    .wght_rd_en   (wght_rd_en),
    .wght_addr    (wght_addr),
    .lyr_ready    (lyr_ready),
    .lyr_iact_vld (lyr_iact_vld),
    .lyr_wght_vld (lyr_wght_vld),
    .lyr_first    (lyr_first),
    .lyr_last     (lyr_last),
    .oact_vld     (oact_vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic step(input logic st, input logic ab, input logic rdy, input logic rn);
    @(negedge clk);
    start     = st;
    abort     = ab;
    lyr_ready = rdy;
    rstN      = rn;
    #1;
  endtask

  function automatic logic [31:0] obs_flags();
    return {23'd0, busy, done, oact_vld, wght_rd_en, iact_rd_en,
            lyr_wght_vld, lyr_iact_vld, lyr_first, lyr_last};
  endfunction

  // One pass starting with a start pulse at c=0. Extra start pulses at c=10 and on the
  // done cycle must be ignored. abort_tap/rst_c < 0 disable abort / mid-pass reset.
  task automatic run_pass(input string nm, input int stall_pct, input bit directed,
                          input int abort_tap, input int rst_c);
    int taps, done_c, end_c, held, beats, ibeats;
    bit live, bz, rw, ri, rf, rl, finished;
    taps = 0; done_c = -1; end_c = -1; held = 0; beats = 0; ibeats = 0;
    live = 1; bz = 0; rw = 0; ri = 0; rf = 0; rl = 0; finished = 0;
    for (int c = 0; c < 2000 && !finished; c++) begin
      bit feed, rdy, ab, st, in_rst, w, i, de;
      in_rst = (rst_c >= 0) && (c >= rst_c) && (c < rst_c + 3);
      if (in_rst) begin
        live = 0; bz = 0; rw = 0; ri = 0; rf = 0; rl = 0;
      end
      feed = live && (c >= 1) && (taps < NT);
      rdy  = ($urandom_range(99) >= stall_pct);
      if (directed && feed && (taps == 5 || taps == 20) && held < 3) begin
        rdy = 0;
        held++;
      end
      ab = feed && (abort_tap >= 0) && (taps == abort_tap);
      st = (c == 0) || (c == 10) || (live && c == done_c);
      w  = feed && rdy;
      i  = w && (taps < NP);
      de = live && (c == done_c);

      step(st, ab, rdy, !in_rst);
      chk($sformatf("%s c%0d flags", nm, c), obs_flags(),
          {23'd0, bz, de, de, w, i, rw, ri, rf, rl});
      if (feed) begin
        chk($sformatf("%s c%0d wght_addr", nm, c), 32'(wght_addr), 32'(taps));
        if (taps < NP) chk($sformatf("%s c%0d iact_addr", nm, c), 32'(iact_addr), 32'(taps));
      end
      if (lyr_wght_vld) beats++;
      if (lyr_iact_vld) ibeats++;

      rw = w && !ab && !in_rst;
      ri = i && !ab && !in_rst;
      rf = w && !ab && !in_rst && (taps == 0);
      rl = w && !ab && !in_rst && (taps == NT - 1);
      if (in_rst || ab || de) bz = 0;
      else if (c == 0) bz = 1;
      if (w) begin
        held = 0;
        taps++;
        if (taps == NT) done_c = c + DR + 1;
      end
      if (ab) begin
        live  = 0;
        end_c = c + 1;
      end
      if (de) end_c = c + 2;
      if (rst_c >= 0 && c == rst_c + 3) end_c = c + 1;
      if (c == end_c) finished = 1;
    end
    chk({nm, " completed"}, 32'(finished), 32'd1);
    if (abort_tap < 0 && rst_c < 0) begin
      chk({nm, " wght beats"}, 32'(beats), 32'(NT));
      chk({nm, " iact beats"}, 32'(ibeats), 32'(NP));
    end
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; abort = 1'b0; lyr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("reset flags %0d", k), obs_flags(), 32'd0);
      chk($sformatf("reset addrs %0d", k), {22'd0, iact_addr, wght_addr}, 32'd0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("post-reset idle flags", obs_flags(), 32'd0);

    run_pass("basic", 0, 1'b0, -1, -1);
    run_pass("stall5_20", 0, 1'b1, -1, -1);
    run_pass("rand30", 30, 1'b0, -1, -1);
    run_pass("rand60", 60, 1'b0, -1, -1);
    run_pass("abort30", 0, 1'b0, 30, -1);
    run_pass("restart", 20, 1'b0, -1, -1);
    run_pass("rst_drain", 0, 1'b0, -1, 52);
    run_pass("after_rst", 0, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
